// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: two-flop synchronizer, mid-bit sampling, framing-error
// detection and line-break suppression. Delivers each good byte with a one-cycle strobe.
module uart_receiver #(
  parameter int unsigned FREQUENCY = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_Serial_Data,
  output logic       o_DV,
  output logic [7:0] o_Byte,
  output logic       o_Frame_Err,
  output logic       o_Sig_Active
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((FREQUENCY - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FREQUENCY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CLEANUP,
    S_BREAK
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                rx_q, rx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic                dv_q, dv_d;
  logic                ferr_q, ferr_d;
  logic                active_q, active_d;

  // Synchronizer flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      rx_q     <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      rx_q     <= rx_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d  = state_q;
    sync1_d  = i_Serial_Data;
    rx_d     = sync1_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        if (!rx_q) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end

      // Re-check the line at the start-bit centre to reject glitches.
      S_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_q) begin
            state_d = S_DATA;
          end else begin
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_q;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_q) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = S_CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CLEANUP: state_d = S_IDLE;

      // Wait out a held-low line so it is not decoded as repeated 0x00 frames.
      S_BREAK: begin
        if (rx_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_DV         = dv_q;
  assign o_Byte       = byte_q;
  assign o_Frame_Err  = ferr_q;
  assign o_Sig_Active = active_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized bench for uart_receiver: a bit-level line driver plus a frame-level
// expectation queue predicting every o_DV / o_Frame_Err pulse and the o_Byte it carries.
module tb_uart_receiver;

  localparam int unsigned FREQ = 87;
  localparam int unsigned HALF = (FREQ - 1) / 2;
  localparam int unsigned DV_LATENCY = 9 * FREQ + HALF + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial = 1'b1;
  logic       o_DV;
  logic [7:0] o_Byte;
  logic       o_Frame_Err;
  logic       o_Sig_Active;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned last_dv_cyc = 0;
  int unsigned dv_cnt = 0;
  int unsigned ferr_cnt = 0;

  // Expectation entries: bit 8 = framing error, bits 7:0 = byte for a good frame.
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  logic [7:0] model_byte = 8'h00;

  logic dv_prev = 1'b0;
  logic ferr_prev = 1'b0;
  logic active_prev = 1'b0;
  logic active_sticky = 1'b0;
  logic brk_mon = 1'b0;
  logic brk_sticky = 1'b0;

  uart_receiver #(.FREQUENCY(FREQ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_Serial_Data(serial),
    .o_DV         (o_DV),
    .o_Byte       (o_Byte),
    .o_Frame_Err  (o_Frame_Err),
    .o_Sig_Active (o_Sig_Active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pulse monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_DV || o_Frame_Err) begin
        check_eq("pulse_exclusive", 32'(o_DV & o_Frame_Err), 32'd0);
        check_eq("pulse_width", 32'(dv_prev | ferr_prev), 32'd0);
        if (o_DV) begin
          dv_cnt++;
          last_dv_cyc = cyc;
        end
        if (o_Frame_Err) ferr_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse", 32'({o_Frame_Err, o_DV}), 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check_eq("pulse_kind", 32'(o_Frame_Err), 32'(exp_e[8]));
          if (!exp_e[8]) model_byte = exp_e[7:0];
          check_eq("pulse_byte", 32'(o_Byte), 32'(model_byte));
        end
      end
      if (o_Sig_Active && !active_prev) rise_cyc = cyc;
      active_sticky = active_sticky | o_Sig_Active;
      if (brk_mon) brk_sticky = brk_sticky | o_Sig_Active | o_DV | o_Frame_Err;
    end
    dv_prev     = o_DV;
    ferr_prev   = o_Frame_Err;
    active_prev = o_Sig_Active;
  end

  task automatic send_bit(input logic b);
    serial = b;
    repeat (FREQ) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop);
  endtask

  task automatic expect_frame(input logic [7:0] data, input logic stop);
    exp_q.push_back({~stop, data});
  endtask

  initial begin
    int unsigned s;
    int unsigned dv_before;
    logic [10:0] quiet_acc;
    logic [7:0] rb;
    logic rstop;
    logic [7:0] b77;

    // Reset with idle line, then 500 quiet cycles.
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("reset_outputs", 32'({o_DV, o_Frame_Err, o_Sig_Active, o_Byte}), 32'd0);
    rst_n = 1'b1;
    quiet_acc = '0;
    repeat (500) begin
      @(negedge clk);
      quiet_acc = quiet_acc | {o_DV, o_Frame_Err, o_Sig_Active, o_Byte};
    end
    check_eq("idle_quiet", 32'(quiet_acc), 32'd0);

    // 0xA5 with exact edge timing.
    expect_frame(8'hA5, 1'b1);
    s = cyc;
    send_frame(8'hA5, 1'b1);
    check_eq("a5_active_rise", rise_cyc - s, 32'd3);
    check_eq("a5_dv_latency", last_dv_cyc - s, 32'(DV_LATENCY));
    check_eq("a5_dv_count", dv_cnt, 32'd1);
    check_eq("a5_no_ferr", ferr_cnt, 32'd0);
    check_eq("a5_byte", 32'(o_Byte), 32'hA5);
    check_eq("a5_active_low", 32'(o_Sig_Active), 32'd0);

    // 20-cycle start glitch.
    repeat (FREQ) @(negedge clk);
    active_sticky = 1'b0;
    serial = 1'b0;
    repeat (20) @(negedge clk);
    serial = 1'b1;
    repeat (2 * FREQ) @(negedge clk);
    check_eq("glitch_active_seen", 32'(active_sticky), 32'd1);
    check_eq("glitch_active_drop", 32'(o_Sig_Active), 32'd0);
    check_eq("glitch_no_dv", dv_cnt, 32'd1);
    check_eq("glitch_no_ferr", ferr_cnt, 32'd0);
    check_eq("glitch_byte", 32'(o_Byte), 32'hA5);

    // Bad stop bit then line held low for 5 bit times.
    expect_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0);
    brk_sticky = 1'b0;
    brk_mon = 1'b1;
    serial = 1'b0;
    repeat (5 * FREQ) @(negedge clk);
    brk_mon = 1'b0;
    check_eq("break_quiet", 32'(brk_sticky), 32'd0);
    check_eq("break_ferr_count", ferr_cnt, 32'd1);
    check_eq("break_no_dv", dv_cnt, 32'd1);
    check_eq("break_byte_held", 32'(o_Byte), 32'hA5);
    serial = 1'b1;
    repeat (FREQ) @(negedge clk);
    expect_frame(8'h0F, 1'b1);
    send_frame(8'h0F, 1'b1);
    check_eq("after_break_byte", 32'(o_Byte), 32'h0F);
    check_eq("after_break_dv", dv_cnt, 32'd2);

    // Back-to-back frames with no idle gap.
    expect_frame(8'h00, 1'b1);
    expect_frame(8'hFF, 1'b1);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    repeat (FREQ) @(negedge clk);
    check_eq("b2b_dv_count", dv_cnt, 32'd5);
    check_eq("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("b2b_ferr_count", ferr_cnt, 32'd1);

    // Random frames, occasional bad stop bits, random idle gaps.
    for (int n = 0; n < 12; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(3) != 0);
      expect_frame(rb, rstop);
      send_frame(rb, rstop);
      serial = 1'b1;
      if (!rstop) repeat (FREQ + $urandom_range(20)) @(negedge clk);
      else if ($urandom_range(1) != 0) repeat ($urandom_range(40)) @(negedge clk);
    end
    repeat (FREQ) @(negedge clk);
    check_eq("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of data bit 4 of 0x77.
    b77 = 8'h77;
    dv_before = dv_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b77[i]);
    serial = b77[4];
    repeat (FREQ / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midframe_reset_outputs", 32'({o_DV, o_Frame_Err, o_Sig_Active, o_Byte}), 32'd0);
    serial = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    model_byte = 8'h00;
    repeat (2 * FREQ) @(negedge clk);
    check_eq("midframe_no_pulse", dv_cnt - dv_before, 32'd0);
    check_eq("midframe_byte_zero", 32'(o_Byte), 32'd0);
    expect_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b1);
    repeat (FREQ) @(negedge clk);
    check_eq("post_reset_byte", 32'(o_Byte), 32'h5A);
    check_eq("post_reset_dv", dv_cnt - dv_before, 32'd1);
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage: the downstream consumer of the UART transmitter's serial line.
- Frame format is 8N1, LSB first: start bit (0), 8 data bits, stop bit (1), idle high.
- Recovers each byte by mid-bit sampling and presents it with a one-cycle valid strobe.
- Flags framing errors and rejects start-bit glitches, so loopback tests against the transmitter are self-checking.

Parameters:
- FREQUENCY, 87: clock cycles per bit; must match the transmitter. Legal range 4..256.
- HALF (derived, not overridable): (FREQUENCY-1)/2, integer division. Start-bit mid-point count.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_Serial_Data  input  1  asynchronous serial line, idle high.
- o_DV  output  1  one-cycle pulse; o_Byte is valid in that cycle.
- o_Byte  output  8  last correctly received byte; held until the next good frame.
- o_Frame_Err  output  1  one-cycle pulse when the stop bit samples 0.
- o_Sig_Active  output  1  high while a frame is being received (START through STOP).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; counter, bit index, o_Byte, o_DV, o_Frame_Err and o_Sig_Active all go to 0.
  - Both synchronizer flops are set to 1.
  - Reset mid-frame abandons the frame and produces no pulse.
- Input synchronizer: two flops, sync1 <= pin, rx <= sync1. All decisions use rx only.
- Counter: 8-bit, counts 0..FREQUENCY-1. Bit index: 3-bit.
- IDLE:
  - Counter = 0, index = 0, o_Sig_Active = 0.
  - rx=0 -> START, o_Sig_Active <= 1.
- START:
  - Counter increments each cycle.
  - At counter==HALF: if rx=0, counter <= 0 and go to DATA; if rx=1, this is a glitch: go to IDLE, o_Sig_Active <= 0, no pulse.
- DATA:
  - Counter increments. At counter==FREQUENCY-1: shift register[index] <= rx, counter <= 0.
  - index<7 -> index+1 and stay in DATA; index==7 -> index <= 0 and go to STOP.
  - The sample point is therefore one full bit after the start mid-point, i.e. the centre of each data bit.
- STOP:
  - At counter==FREQUENCY-1, o_Sig_Active <= 0 and counter <= 0.
  - rx=1: o_Byte <= shift register, o_DV <= 1, go to CLEANUP.
  - rx=0: o_Frame_Err <= 1, o_Byte unchanged, go to BREAK.
- CLEANUP: o_DV <= 0; go to IDLE next cycle.
- BREAK:
  - o_Frame_Err <= 0.
  - Stay while rx=0 (line break or long-low line). rx=1 -> IDLE.
  - A held-low line must not be decoded as repeated 0x00 frames.
- Pulse rules:
  - o_DV and o_Frame_Err are each exactly 1 cycle wide and mutually exclusive.
  - Neither pulse is ever asserted outside STOP exit.
- Latency: o_DV is high in the cycle following clock edge 9*FREQUENCY + HALF + 4, counted from the first edge that samples the pin low. For FREQUENCY=87 that is edge 830.
- Back-to-back frames:
  - The receiver is back in IDLE about half a bit before the nominal end of the stop bit.
  - A start bit immediately following a stop bit must be received with no gap required.
- Unsupported: baud drift beyond ±(HALF-2) cycles over 10 bits. No parity, no FIFO; the consumer must take o_Byte on o_DV.

Test Plan:
- Reset held with pin idle high, then released for 500 cycles -> o_DV=0, o_Frame_Err=0, o_Sig_Active=0, o_Byte=0x00 throughout.
- Drive 0xA5 frame at FREQUENCY=87 -> o_Sig_Active rises 3 edges after the start edge; o_DV is a single cycle at edge 830±0; o_Byte=0xA5; o_Frame_Err stays 0.
- 20-cycle low glitch on an idle line -> o_Sig_Active pulses high then drops at the START check; no o_DV and no o_Frame_Err; o_Byte unchanged.
- 0x3C frame with stop bit forced 0, line then held low for 5 more bit times -> one o_Frame_Err pulse; no o_DV; o_Byte keeps 0xA5; no further activity until the line goes high. A following 0x0F frame is received correctly.
- Loopback from the transmitter sending 0x00, 0xFF, 0x81 back-to-back -> three o_DV pulses with o_Byte values 0x00, 0xFF, 0x81 in order; zero frame errors.
- rst_n asserted during data bit 4 of a 0x77 frame, then released -> all outputs 0 immediately and no pulse. The next 0x5A frame is received correctly with o_DV and o_Byte=0x5A.
